// File: rtl/traffic_pkg.sv
// Shared lamp codes, phase encodings and sizing helper for the multi-approach
// intersection controller.
package traffic_pkg;

    localparam logic [2:0] LIGHT_GREEN  = 3'b001;
    localparam logic [2:0] LIGHT_YELLOW = 3'b010;
    localparam logic [2:0] LIGHT_RED    = 3'b100;
    localparam logic [2:0] LIGHT_DARK   = 3'b000;

    typedef enum logic [2:0] {
        PH_ALL_RED = 3'd0,
        PH_GREEN   = 3'd1,
        PH_YELLOW  = 3'd2,
        PH_PREEMPT = 3'd3,
        PH_FLASH   = 3'd4
    } phase_t;

    function automatic int max_cyc(input int a, input int b, input int c, input int d);
        int m;
        m = a;
        if (b > m) m = b;
        if (c > m) m = c;
        if (d > m) m = d;
        return m;
    endfunction

endpackage

// File: rtl/traffic_next_dir.sv
// Round-robin demand search: first direction after cur_dir with its sensor set,
// falling back to plain rotation when nobody is waiting.
module traffic_next_dir #(
    parameter int NUM_DIR = 4,
    localparam int DIR_W = $clog2(NUM_DIR)
) (
    input  logic [NUM_DIR-1:0] sensor,
    input  logic [DIR_W-1:0]   cur_dir,
    output logic [DIR_W-1:0]   next_dir
);

    logic             found;
    logic [DIR_W-1:0] idx;

    // k == NUM_DIR lands back on cur_dir, so a lone self-demand keeps the same owner
    always_comb begin
        next_dir = DIR_W'((int'(cur_dir) + 1) % NUM_DIR);
        found    = 1'b0;
        idx      = '0;
        for (int k = 1; k <= NUM_DIR; k++) begin
            idx = DIR_W'((int'(cur_dir) + k) % NUM_DIR);
            if (!found && sensor[idx]) begin
                next_dir = idx;
                found    = 1'b1;
            end
        end
    end

endmodule

// File: rtl/traffic_control_multi.sv
// Intersection phase sequencer: green/yellow/all-red rotation over demanding
// approaches, emergency preemption and a flashing night mode.
module traffic_control_multi
    import traffic_pkg::*;
#(
    parameter int NUM_DIR    = 4,
    parameter int GREEN_CYC  = 16,
    parameter int YELLOW_CYC = 8,
    parameter int ALLRED_CYC = 2,
    parameter int FLASH_CYC  = 4,
    localparam int DIR_W = $clog2(NUM_DIR)
) (
    input  logic                 clk,
    input  logic                 rst_a,
    input  logic [NUM_DIR-1:0]   sensor,
    input  logic                 emerg_req,
    input  logic [DIR_W-1:0]     emerg_dir,
    input  logic                 flash_mode,
    output logic [3*NUM_DIR-1:0] lights,
    output logic [DIR_W-1:0]     active_dir,
    output logic [2:0]           phase
);

    localparam int CNT_W = $clog2(max_cyc(GREEN_CYC, YELLOW_CYC, ALLRED_CYC, FLASH_CYC) + 1);
    localparam int LW    = 3 * NUM_DIR;
    localparam logic [CNT_W-1:0] T_GREEN  = CNT_W'(GREEN_CYC);
    localparam logic [CNT_W-1:0] T_YELLOW = CNT_W'(YELLOW_CYC);
    localparam logic [CNT_W-1:0] T_ALLRED = CNT_W'(ALLRED_CYC);
    localparam logic [CNT_W-1:0] T_FLASH  = CNT_W'(FLASH_CYC);
    localparam logic [DIR_W:0]   DIR_LIMIT = NUM_DIR[DIR_W:0];

    phase_t           state;
    logic [CNT_W-1:0] timer;
    logic             blink_on;
    logic             restart;
    logic             emerg_pend;
    logic [DIR_W-1:0] emerg_lat;
    logic [DIR_W-1:0] search_dir;
    logic [DIR_W-1:0] green_dir;
    logic [DIR_W-1:0] emerg_tgt;
    logic             emerg_ok;
    logic             emerg_act;
    logic             tc;

    traffic_next_dir #(.NUM_DIR(NUM_DIR)) u_next_dir (
        .sensor   (sensor),
        .cur_dir  (active_dir),
        .next_dir (search_dir)
    );

    // Once accepted, the request keeps its original target until it drops
    assign emerg_ok  = emerg_req && ({1'b0, emerg_dir} < DIR_LIMIT);
    assign emerg_act = emerg_pend ? emerg_req : emerg_ok;
    assign emerg_tgt = emerg_pend ? emerg_lat : emerg_dir;
    assign green_dir = restart ? '0 : search_dir;
    assign tc        = (timer == CNT_W'(1));
    assign phase     = state;

    function automatic logic [LW-1:0] one_dir(input logic [2:0] lamp, input logic [DIR_W-1:0] dir);
        logic [LW-1:0] w;
        w = '0;
        for (int i = 0; i < NUM_DIR; i++)
            w[3*i +: 3] = (DIR_W'(i) == dir) ? lamp : LIGHT_RED;
        return w;
    endfunction

    function automatic logic [LW-1:0] all_dirs(input logic [2:0] lamp);
        return {NUM_DIR{lamp}};
    endfunction

    always_ff @(posedge clk or posedge rst_a) begin
        if (rst_a) begin
            state      <= PH_ALL_RED;
            timer      <= T_ALLRED;
            active_dir <= '0;
            lights     <= all_dirs(LIGHT_RED);
            blink_on   <= 1'b0;
            restart    <= 1'b1;
            emerg_pend <= 1'b0;
            emerg_lat  <= '0;
        end else begin
            if (flash_mode || state == PH_FLASH || !emerg_req) begin
                emerg_pend <= 1'b0;
            end else if (!emerg_pend && emerg_ok) begin
                emerg_pend <= 1'b1;
                emerg_lat  <= emerg_dir;
            end

            if (flash_mode && state != PH_FLASH) begin
                state    <= PH_FLASH;
                timer    <= T_FLASH;
                blink_on <= 1'b1;
                lights   <= all_dirs(LIGHT_YELLOW);
            end else begin
                case (state)
                    PH_FLASH: begin
                        if (!flash_mode) begin
                            state   <= PH_ALL_RED;
                            timer   <= T_ALLRED;
                            restart <= 1'b1;
                            lights  <= all_dirs(LIGHT_RED);
                        end else if (tc) begin
                            timer    <= T_FLASH;
                            blink_on <= !blink_on;
                            lights   <= all_dirs(blink_on ? LIGHT_DARK : LIGHT_YELLOW);
                        end else begin
                            timer <= timer - 1'b1;
                        end
                    end
                    PH_ALL_RED: begin
                        if (tc) begin
                            restart <= 1'b0;
                            if (emerg_act) begin
                                state      <= PH_PREEMPT;
                                active_dir <= emerg_tgt;
                                lights     <= one_dir(LIGHT_GREEN, emerg_tgt);
                            end else begin
                                state      <= PH_GREEN;
                                timer      <= T_GREEN;
                                active_dir <= green_dir;
                                lights     <= one_dir(LIGHT_GREEN, green_dir);
                            end
                        end else begin
                            timer <= timer - 1'b1;
                        end
                    end
                    PH_GREEN: begin
                        // Preempting to the owner keeps the green lit without a clearance cycle
                        if (emerg_act && emerg_tgt == active_dir) begin
                            state <= PH_PREEMPT;
                        end else if (emerg_act || tc) begin
                            state  <= PH_YELLOW;
                            timer  <= T_YELLOW;
                            lights <= one_dir(LIGHT_YELLOW, active_dir);
                        end else begin
                            timer <= timer - 1'b1;
                        end
                    end
                    PH_YELLOW: begin
                        if (tc) begin
                            state  <= PH_ALL_RED;
                            timer  <= T_ALLRED;
                            lights <= all_dirs(LIGHT_RED);
                        end else begin
                            timer <= timer - 1'b1;
                        end
                    end
                    PH_PREEMPT: begin
                        if (!emerg_req) begin
                            state  <= PH_YELLOW;
                            timer  <= T_YELLOW;
                            lights <= one_dir(LIGHT_YELLOW, active_dir);
                        end
                    end
                    default: begin
                        state  <= PH_ALL_RED;
                        timer  <= T_ALLRED;
                        lights <= all_dirs(LIGHT_RED);
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_traffic_control_multi.sv
// Self-checking bench: expected light/owner/phase traces are built per scenario
// from phase durations and the demand-search rule, then replayed against the DUT.
module tb_traffic_control_multi;

    localparam int N  = 4;
    localparam int G  = 16;
    localparam int Y  = 8;
    localparam int A  = 2;
    localparam int F  = 4;
    localparam int DW = $clog2(N);
    localparam int LW = 3 * N;

    localparam logic [2:0] L_G = 3'b001;
    localparam logic [2:0] L_Y = 3'b010;
    localparam logic [2:0] L_R = 3'b100;
    localparam logic [2:0] L_D = 3'b000;

    localparam logic [2:0] P_RED = 3'd0;
    localparam logic [2:0] P_GRN = 3'd1;
    localparam logic [2:0] P_YEL = 3'd2;
    localparam logic [2:0] P_EMG = 3'd3;
    localparam logic [2:0] P_FLS = 3'd4;

    logic          clk = 1'b0;
    logic          rst_a = 1'b1;
    logic [N-1:0]  sensor = '0;
    logic          emerg_req = 1'b0;
    logic [DW-1:0] emerg_dir = '0;
    logic          flash_mode = 1'b0;
    logic [LW-1:0] lights;
    logic [DW-1:0] active_dir;
    logic [2:0]    phase;

    int checks = 0;
    int failures = 0;
    int lit_cnt;

    typedef struct {
        logic [LW-1:0] l;
        logic [DW-1:0] d;
        logic [2:0]    ph;
        logic [N-1:0]  sens;
        logic          req;
        logic [DW-1:0] edir;
        logic          fl;
    } step_t;

    step_t         plan[$];
    logic [N-1:0]  st_sens;
    logic          st_req;
    logic [DW-1:0] st_edir;
    logic          st_fl;

    traffic_control_multi #(
        .NUM_DIR(N), .GREEN_CYC(G), .YELLOW_CYC(Y), .ALLRED_CYC(A), .FLASH_CYC(F)
    ) dut (
        .clk        (clk),
        .rst_a      (rst_a),
        .sensor     (sensor),
        .emerg_req  (emerg_req),
        .emerg_dir  (emerg_dir),
        .flash_mode (flash_mode),
        .lights     (lights),
        .active_dir (active_dir),
        .phase      (phase)
    );

    always #5 clk = ~clk;

    // Outside flash, no more than one approach may show anything but red
    always @(negedge clk) begin
        if (!rst_a && phase != P_FLS) begin
            lit_cnt = 0;
            for (int i = 0; i < N; i++)
                if (lights[3*i +: 3] != L_R) lit_cnt++;
            checks++;
            if (lit_cnt > 1) begin
                failures++;
                $display("FAIL invariant lit_dirs=%0d allowed<=1 lights=%h", lit_cnt, lights);
            end
        end
    end

    function automatic logic [LW-1:0] one_on(input logic [2:0] lamp, input int dir);
        logic [LW-1:0] v;
        v = '0;
        for (int i = 0; i < N; i++) v[3*i +: 3] = (i == dir) ? lamp : L_R;
        return v;
    endfunction

    function automatic logic [LW-1:0] all_of(input logic [2:0] lamp);
        logic [LW-1:0] v;
        v = '0;
        for (int i = 0; i < N; i++) v[3*i +: 3] = lamp;
        return v;
    endfunction

    function automatic int nxt(input logic [N-1:0] s, input int cur);
        for (int k = 1; k <= N; k++)
            if (((s >> ((cur + k) % N)) & N'(1)) != '0) return (cur + k) % N;
        return (cur + 1) % N;
    endfunction

    task automatic push(input logic [LW-1:0] l, input int d, input logic [2:0] ph, input int n);
        step_t s;
        for (int i = 0; i < n; i++) begin
            s.l = l; s.d = DW'(d); s.ph = ph;
            s.sens = st_sens; s.req = st_req; s.edir = st_edir; s.fl = st_fl;
            plan.push_back(s);
        end
    endtask

    task automatic push_phase(input int d);
        push(one_on(L_G, d), d, P_GRN, G);
        push(one_on(L_Y, d), d, P_YEL, Y);
        push(all_of(L_R), d, P_RED, A);
    endtask

    task automatic new_plan(input logic [N-1:0] s);
        plan.delete();
        st_sens = s; st_req = 1'b0; st_edir = '0; st_fl = 1'b0;
        push(all_of(L_R), 0, P_RED, A);
    endtask

    task automatic do_reset();
        rst_a = 1'b1;
        sensor = '0; emerg_req = 1'b0; emerg_dir = '0; flash_mode = 1'b0;
        @(posedge clk); #1;
        rst_a = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        checks++;
        if (lights !== all_of(L_R)) begin
            failures++; $display("FAIL reset_lights got=%h want=%h", lights, all_of(L_R));
        end
        checks++;
        if (active_dir !== '0) begin
            failures++; $display("FAIL reset_dir got=%0d want=0", active_dir);
        end
        checks++;
        if (phase !== P_RED) begin
            failures++; $display("FAIL reset_phase got=%0d want=%0d", phase, P_RED);
        end
        @(posedge clk); #1;
        checks++;
        if (phase !== P_RED) begin
            failures++; $display("FAIL reset_allred_hold got=%0d want=%0d", phase, P_RED);
        end
        @(posedge clk); #1;
        checks++;
        if (lights !== one_on(L_G, 0)) begin
            failures++; $display("FAIL reset_first_green got=%h want=%h", lights, one_on(L_G, 0));
        end
    endtask

    task automatic test_round_robin();
        int d;
        new_plan(4'b1111);
        d = 0;
        for (int p = 0; p < 5; p++) begin
            push_phase(d);
            d = nxt(st_sens, d);
        end
        do_reset();
        for (int i = 0; i < plan.size(); i++) begin
            if (i > 0) begin @(posedge clk); #1; end
            checks++;
            if (lights !== plan[i].l || active_dir !== plan[i].d || phase !== plan[i].ph) begin
                failures++;
                $display("FAIL round_robin step=%0d lights=%h/%h dir=%0d/%0d phase=%0d/%0d",
                         i, lights, plan[i].l, active_dir, plan[i].d, phase, plan[i].ph);
            end
            sensor = plan[i].sens; emerg_req = plan[i].req;
            emerg_dir = plan[i].edir; flash_mode = plan[i].fl;
        end
    endtask

    task automatic test_sensor_skip();
        logic [N-1:0] s;
        int d;
        for (int it = 0; it < 6; it++) begin
            if (it == 0) s = 4'b1000;
            else if (it == 1) s = 4'b0000;
            else s = N'($urandom_range(0, (1 << N) - 1));
            new_plan(s);
            d = 0;
            for (int p = 0; p < 4; p++) begin
                push_phase(d);
                d = nxt(s, d);
            end
            do_reset();
            for (int i = 0; i < plan.size(); i++) begin
                if (i > 0) begin @(posedge clk); #1; end
                checks++;
                if (lights !== plan[i].l || active_dir !== plan[i].d || phase !== plan[i].ph) begin
                    failures++;
                    $display("FAIL sensor_skip s=%b step=%0d lights=%h/%h dir=%0d/%0d phase=%0d/%0d",
                             s, i, lights, plan[i].l, active_dir, plan[i].d, phase, plan[i].ph);
                end
                sensor = plan[i].sens; emerg_req = plan[i].req;
                emerg_dir = plan[i].edir; flash_mode = plan[i].fl;
            end
        end
    endtask

    task automatic test_emerg_other();
        logic [N-1:0] s;
        int k, tgt, h, d;
        for (int it = 0; it < 4; it++) begin
            if (it == 0) begin
                s = 4'b1111; k = 5; tgt = 2; h = 6;
            end else begin
                s = N'($urandom_range(0, (1 << N) - 1));
                k = $urandom_range(1, G); tgt = $urandom_range(1, N - 1); h = $urandom_range(1, 20);
            end
            new_plan(s);
            st_edir = DW'(tgt);
            push(one_on(L_G, 0), 0, P_GRN, k - 1);
            st_req = 1'b1;
            push(one_on(L_G, 0), 0, P_GRN, 1);
            st_edir = DW'((tgt + 1 + $urandom_range(0, N - 2)) % N);
            push(one_on(L_Y, 0), 0, P_YEL, Y);
            push(all_of(L_R), 0, P_RED, A);
            push(one_on(L_G, tgt), tgt, P_EMG, h - 1);
            st_req = 1'b0;
            push(one_on(L_G, tgt), tgt, P_EMG, 1);
            push(one_on(L_Y, tgt), tgt, P_YEL, Y);
            push(all_of(L_R), tgt, P_RED, A);
            d = nxt(s, tgt);
            push(one_on(L_G, d), d, P_GRN, G);
            do_reset();
            for (int i = 0; i < plan.size(); i++) begin
                if (i > 0) begin @(posedge clk); #1; end
                checks++;
                if (lights !== plan[i].l || active_dir !== plan[i].d || phase !== plan[i].ph) begin
                    failures++;
                    $display("FAIL emerg_other it=%0d step=%0d lights=%h/%h dir=%0d/%0d phase=%0d/%0d",
                             it, i, lights, plan[i].l, active_dir, plan[i].d, phase, plan[i].ph);
                end
                sensor = plan[i].sens; emerg_req = plan[i].req;
                emerg_dir = plan[i].edir; flash_mode = plan[i].fl;
            end
        end
    endtask

    task automatic test_emerg_same();
        int de, k, h, d;
        for (int it = 0; it < 3; it++) begin
            de = (it == 0) ? 2 : $urandom_range(0, N - 1);
            k  = $urandom_range(1, G);
            h  = G + $urandom_range(1, 10);
            new_plan(4'b1111);
            for (int p = 0; p < de; p++) push_phase(p);
            st_edir = DW'(de);
            push(one_on(L_G, de), de, P_GRN, k - 1);
            st_req = 1'b1;
            push(one_on(L_G, de), de, P_GRN, 1);
            st_edir = DW'((de + 1) % N);
            push(one_on(L_G, de), de, P_EMG, h - 1);
            st_req = 1'b0;
            push(one_on(L_G, de), de, P_EMG, 1);
            push(one_on(L_Y, de), de, P_YEL, Y);
            push(all_of(L_R), de, P_RED, A);
            d = nxt(st_sens, de);
            push(one_on(L_G, d), d, P_GRN, G);
            do_reset();
            for (int i = 0; i < plan.size(); i++) begin
                if (i > 0) begin @(posedge clk); #1; end
                checks++;
                if (lights !== plan[i].l || active_dir !== plan[i].d || phase !== plan[i].ph) begin
                    failures++;
                    $display("FAIL emerg_same it=%0d step=%0d lights=%h/%h dir=%0d/%0d phase=%0d/%0d",
                             it, i, lights, plan[i].l, active_dir, plan[i].d, phase, plan[i].ph);
                end
                sensor = plan[i].sens; emerg_req = plan[i].req;
                emerg_dir = plan[i].edir; flash_mode = plan[i].fl;
            end
        end
    endtask

    task automatic test_flash();
        int owner, k, len;
        for (int it = 0; it < 2; it++) begin
            new_plan(4'b1111);
            if (it == 0) begin
                owner = 0; k = 3;
                push(one_on(L_G, 0), 0, P_GRN, G);
                push(one_on(L_Y, 0), 0, P_YEL, k - 1);
                st_fl = 1'b1; st_req = 1'b1; st_edir = DW'($urandom_range(0, N - 1));
                push(one_on(L_Y, 0), 0, P_YEL, 1);
            end else begin
                owner = 1; k = $urandom_range(1, G);
                push_phase(0);
                push(one_on(L_G, 1), 1, P_GRN, k - 1);
                st_fl = 1'b1; st_req = 1'b1; st_edir = DW'($urandom_range(0, N - 1));
                push(one_on(L_G, 1), 1, P_GRN, 1);
            end
            len = 4 * F + $urandom_range(0, 2 * F);
            for (int c = 0; c < len; c++) begin
                if (c == len - 1) begin st_fl = 1'b0; st_req = 1'b0; end
                push(all_of(((c / F) % 2 == 0) ? L_Y : L_D), owner, P_FLS, 1);
            end
            push(all_of(L_R), owner, P_RED, A);
            push(one_on(L_G, 0), 0, P_GRN, G);
            do_reset();
            for (int i = 0; i < plan.size(); i++) begin
                if (i > 0) begin @(posedge clk); #1; end
                checks++;
                if (lights !== plan[i].l || active_dir !== plan[i].d || phase !== plan[i].ph) begin
                    failures++;
                    $display("FAIL flash it=%0d step=%0d lights=%h/%h dir=%0d/%0d phase=%0d/%0d",
                             it, i, lights, plan[i].l, active_dir, plan[i].d, phase, plan[i].ph);
                end
                sensor = plan[i].sens; emerg_req = plan[i].req;
                emerg_dir = plan[i].edir; flash_mode = plan[i].fl;
            end
        end
    endtask

    task automatic test_async_reset();
        logic [N-1:0] s;
        int d;
        s = N'($urandom_range(0, (1 << N) - 1));
        new_plan(s);
        d = 0;
        for (int p = 0; p < 3; p++) begin
            push_phase(d);
            d = nxt(s, d);
        end
        do_reset();
        sensor = 4'b1111;
        for (int c = 0; c < A - 1 + G + Y + A + 5; c++) begin
            @(posedge clk); #1;
        end
        #3 rst_a = 1'b1;
        #1;
        checks++;
        if (lights !== all_of(L_R)) begin
            failures++; $display("FAIL async_reset_lights got=%h want=%h", lights, all_of(L_R));
        end
        checks++;
        if (active_dir !== '0 || phase !== P_RED) begin
            failures++; $display("FAIL async_reset_state dir=%0d/0 phase=%0d/%0d", active_dir, phase, P_RED);
        end
        @(posedge clk); #1;
        rst_a = 1'b0;
        for (int i = 0; i < plan.size(); i++) begin
            if (i > 0) begin @(posedge clk); #1; end
            checks++;
            if (lights !== plan[i].l || active_dir !== plan[i].d || phase !== plan[i].ph) begin
                failures++;
                $display("FAIL async_restart step=%0d lights=%h/%h dir=%0d/%0d phase=%0d/%0d",
                         i, lights, plan[i].l, active_dir, plan[i].d, phase, plan[i].ph);
            end
            sensor = plan[i].sens; emerg_req = plan[i].req;
            emerg_dir = plan[i].edir; flash_mode = plan[i].fl;
        end
    endtask

    initial begin
        test_reset();
        test_round_robin();
        test_sensor_skip();
        test_emerg_other();
        test_emerg_same();
        test_flash();
        test_async_reset();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #400000;
        $display("FAIL watchdog time limit reached checks=%0d failures=%0d", checks, failures);
        $fatal(1, "watchdog");
    end

endmodule
